tmds_word_aligner: RTL and testbench
====================================

Name: tmds_word_aligner

Overview:
- Parametrised per-channel TMDS word aligner. Sits after the de-serializer and before the TMDS decoder in HDMI_RX.
- Takes unaligned raw 10-bit words from NUM_CH lanes and locks each lane's bit offset by hunting for TMDS control tokens.
- Presents aligned 10-bit words plus per-lane lock and offset status.
- Generalises the fixed 3-lane de-serializer path: any lane count, autonomous bitslip, lock/loss tracking.

Parameters:
- NUM_CH, 3, number of TMDS lanes (blue = lane 0, green = 1, red = 2).
- SEARCH_TO, 1024, cycles without a token at the current offset before slipping one bit.
- LOCK_CNT, 16, consecutive control tokens needed to declare lock.
- LOSS_TO, 2000000, cycles without any token while locked before dropping lock.

Ports:
- i_pixclk  in  1  pixel clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_raw  in  NUM_CH*10  unaligned raw words; lane k at [k*10 +: 10].
- i_realign  in  1  single-cycle pulse; forces every lane back to SEARCH.
- o_word  out  NUM_CH*10  aligned words; same lane packing as i_raw.
- o_locked  out  NUM_CH  per-lane lock flag.
- o_all_locked  out  1  AND of all o_locked bits, registered.
- o_offset  out  NUM_CH*4  per-lane current bit offset, 0..9.

Behaviour:
- Reset: o_word = 0, o_locked = 0, o_all_locked = 0, o_offset = 0. All lanes in SEARCH; all counters 0.
- Per lane: r_prev <= raw word every cycle.
- Window w = {raw_cur, r_prev} (20 bits, older word in the low bits). Candidate c = w[offset +: 10].
- o_word <= c, registered. At offset 0, o_word equals the raw word from 2 cycles earlier.
- Token set: 1101010100, 0010101011, 0101010100, 1010101011. tok = (c is in the token set); combinational on the same c.
- FSM per lane: SEARCH, VERIFY, LOCKED.
  - SEARCH, tok = 1: go to VERIFY with run = 1; clear miss counter.
  - SEARCH, tok = 0: miss counter increments. When it reaches SEARCH_TO-1: offset = (offset == 9) ? 0 : offset+1, miss counter clears, stay in SEARCH.
  - VERIFY, tok = 1: run increments. When run reaches LOCK_CNT, go to LOCKED.
  - VERIFY, tok = 0: go to SEARCH; run and miss counter clear; offset unchanged.
  - LOCKED, tok = 1: loss timer clears.
  - LOCKED, tok = 0: loss timer increments. When it reaches LOSS_TO-1: go to SEARCH and slip offset by 1 (9 wraps to 0).
- o_locked[k] is registered (state == LOCKED). It asserts the cycle after the transition into LOCKED.
- i_realign: all lanes go to SEARCH next cycle; offsets are kept; counters clear. It has priority over every FSM transition in the same cycle.
- Counter widths: $clog2 of each timeout/count value. Counters never wrap; each one clears on its transition.
- Reset asserted mid-operation: immediate return to reset values, regardless of clock.

Optional Feature:
- Macro: TMDS_ALIGN_STATS_EN.
- Defined:
  - Adds output o_slip_cnt, NUM_CH*8 bits.
  - Per-lane 8-bit counter, saturating at 255, incremented on every offset slip (SEARCH timeout or loss of lock).
  - Cleared by reset only; i_realign does not clear it.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package tmds_pkg:
  - TMDS_W = 10.
  - The four control-token constants.
  - FSM state encoding (2 bits).
  - Offset width = 4.
- One natural sub-module, tmds_lane_align: single-lane window, candidate select, FSM and counters.
- The top generates NUM_CH instances, plus the all-locked AND and the packing.

Test Plan:
- Reset check: hold i_rst_n low for 5 cycles with random i_raw -> o_word = 0, o_locked = 0, o_offset = 0 throughout.
- Offset-3 lock (SEARCH_TO = 16, LOCK_CNT = 8): lane 0 fed {T[6:0],T[9:7]} every cycle with T = 1101010100 -> lane 0 slips 0, 1, 2, 3; o_offset = 3; o_locked rises by cycle 60; o_word = 1101010100 thereafter.
- Three lanes at offsets 0, 5, 9 using different tokens -> each lane reports its own offset. o_all_locked rises one cycle after the last lane locks.
- Broken VERIFY: after 4 tokens at a lane's lock offset, inject one non-token word -> lane returns to SEARCH with the same offset and does not lock until 8 fresh consecutive tokens arrive.
- Loss of lock (LOSS_TO = 32): once locked, feed random non-token data for 32 cycles -> o_locked falls and o_offset increments by 1. With TMDS_ALIGN_STATS_EN, o_slip_cnt also increments.
- i_realign pulse while all lanes are locked -> all o_locked = 0 two cycles later; offsets unchanged; lanes relock after LOCK_CNT tokens with no slips.

Source files
------------

// File: rtl/tmds_pkg.sv
// Purpose: shared TMDS alignment constants (word width, control tokens, lane FSM encoding).
// Latency: none, declarations only.
// Backpressure: none, declarations only. Optional slip statistics: TMDS_ALIGN_STATS_EN.
package tmds_pkg;

   localparam int TMDS_W = 10;
   localparam int OFF_W  = 4;
   localparam int SLIP_W = 8;

   // Highest legal bit offset; one more slip wraps back to 0.
   localparam logic [OFF_W-1:0] OFF_LAST = 4'd9;

   // The four TMDS control-period tokens (C1,C0 = 00, 01, 10, 11).
   localparam logic [TMDS_W-1:0] TOK_C00 = 10'b1101010100;
   localparam logic [TMDS_W-1:0] TOK_C01 = 10'b0010101011;
   localparam logic [TMDS_W-1:0] TOK_C10 = 10'b0101010100;
   localparam logic [TMDS_W-1:0] TOK_C11 = 10'b1010101011;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } lane_st_t;

   function automatic logic is_ctrl_token(input logic [TMDS_W-1:0] c);
      return (c == TOK_C00) || (c == TOK_C01) || (c == TOK_C10) || (c == TOK_C11);
   endfunction

endpackage

// File: rtl/tmds_lane_align.sv
// Purpose: single-lane TMDS word aligner; hunts control tokens and bitslips until locked.
// Latency: aligned word registered one cycle after the window; two cycles raw->word at offset 0.
// Backpressure: none, consumes one raw word per cycle. Slip counter exists with TMDS_ALIGN_STATS_EN.
module tmds_lane_align
   import tmds_pkg::*;
#(
   parameter int SEARCH_TO = 1024,
   parameter int LOCK_CNT  = 16,
   parameter int LOSS_TO   = 2000000
) (
   input  logic              pixclk,
   input  logic              rst_n,
   input  logic [TMDS_W-1:0] raw,
   input  logic              realign,
   output logic [TMDS_W-1:0] word,
   output logic              locked,
   output logic [OFF_W-1:0]  offset
`ifdef TMDS_ALIGN_STATS_EN
   ,output logic [SLIP_W-1:0] slip_cnt
`endif
);

   localparam int MISS_W = (SEARCH_TO > 1) ? $clog2(SEARCH_TO) : 1;
   localparam int RUN_W  = (LOCK_CNT  > 1) ? $clog2(LOCK_CNT)  : 1;
   localparam int LOSS_W = (LOSS_TO   > 1) ? $clog2(LOSS_TO)   : 1;

   // Counters stop one short of their limit: the final event triggers the transition
   // instead of being stored, so each counter fits in $clog2 of its limit.
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(SEARCH_TO - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TO - 1);

   lane_st_t            st, st_nxt;
   logic [TMDS_W-1:0]   r_prev;
   logic [2*TMDS_W-1:0] win;
   logic [TMDS_W-1:0]   cand;
   logic                tok;
   logic [MISS_W-1:0]   miss, miss_nxt;
   logic [RUN_W-1:0]    run, run_nxt;
   logic [LOSS_W-1:0]   loss, loss_nxt;
   logic                slip;

   // Older word sits in the low bits so increasing offset moves toward newer bits.
   assign win  = {raw, r_prev};
   assign cand = TMDS_W'(win >> offset);
   assign tok  = is_ctrl_token(cand);

   // State register.
   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) st <= ST_SEARCH;
      else        st <= st_nxt;
   end

   // Next-state decode; realign overrides every other transition.
   always_comb begin
      st_nxt = st;
      if (realign) begin
         st_nxt = ST_SEARCH;
      end else begin
         case (st)
            ST_SEARCH: if (tok) st_nxt = ST_VERIFY;
            ST_VERIFY: begin
               if (!tok)                 st_nxt = ST_SEARCH;
               else if (run == RUN_LAST) st_nxt = ST_LOCKED;
            end
            ST_LOCKED: if (!tok && (loss == LOSS_LAST)) st_nxt = ST_SEARCH;
            default:   st_nxt = ST_SEARCH;
         endcase
      end
   end

   // Counter updates and slip strobe for the current state.
   always_comb begin
      slip     = 1'b0;
      miss_nxt = '0;
      run_nxt  = '0;
      loss_nxt = '0;
      if (!realign) begin
         case (st)
            ST_SEARCH: begin
               if (tok)                     run_nxt  = RUN_W'(1);
               else if (miss == MISS_LAST)  slip     = 1'b1;
               else                         miss_nxt = miss + MISS_W'(1);
            end
            ST_VERIFY: begin
               if (tok && (run != RUN_LAST)) run_nxt = run + RUN_W'(1);
            end
            ST_LOCKED: begin
               if (!tok) begin
                  if (loss == LOSS_LAST) slip     = 1'b1;
                  else                   loss_nxt = loss + LOSS_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Window history, aligned word, lock flag, offset and counters.
   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= '0;
         word   <= '0;
         locked <= 1'b0;
         offset <= '0;
         miss   <= '0;
         run    <= '0;
         loss   <= '0;
      end else begin
         r_prev <= raw;
         word   <= cand;
         locked <= (st == ST_LOCKED);
         miss   <= miss_nxt;
         run    <= run_nxt;
         loss   <= loss_nxt;
         if (slip) offset <= (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);
      end
   end

`ifdef TMDS_ALIGN_STATS_EN
   // Saturating count of bit slips; only reset clears it.
   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n)                          slip_cnt <= '0;
      else if (slip && (slip_cnt != '1))   slip_cnt <= slip_cnt + SLIP_W'(1);
   end
`endif

endmodule

// File: rtl/tmds_word_aligner.sv
// Purpose: NUM_CH-lane TMDS word aligner between de-serializer and TMDS decoder.
// Latency: two cycles raw->aligned word at offset 0; all-locked one cycle after the last lane lock.
// Backpressure: none, every lane consumes a word per cycle. o_slip_cnt exists with TMDS_ALIGN_STATS_EN.
module tmds_word_aligner
   import tmds_pkg::*;
#(
   parameter int NUM_CH    = 3,
   parameter int SEARCH_TO = 1024,
   parameter int LOCK_CNT  = 16,
   parameter int LOSS_TO   = 2000000
) (
   input  logic                     i_pixclk,
   input  logic                     i_rst_n,
   input  logic [NUM_CH*TMDS_W-1:0] i_raw,
   input  logic                     i_realign,
   output logic [NUM_CH*TMDS_W-1:0] o_word,
   output logic [NUM_CH-1:0]        o_locked,
   output logic                     o_all_locked,
   output logic [NUM_CH*OFF_W-1:0]  o_offset
`ifdef TMDS_ALIGN_STATS_EN
   ,output logic [NUM_CH*SLIP_W-1:0] o_slip_cnt
`endif
);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      tmds_lane_align #(
         .SEARCH_TO (SEARCH_TO),
         .LOCK_CNT  (LOCK_CNT),
         .LOSS_TO   (LOSS_TO)
      ) u_lane (
         .pixclk   (i_pixclk),
         .rst_n    (i_rst_n),
         .raw      (i_raw[k*TMDS_W +: TMDS_W]),
         .realign  (i_realign),
         .word     (o_word[k*TMDS_W +: TMDS_W]),
         .locked   (o_locked[k]),
         .offset   (o_offset[k*OFF_W +: OFF_W])
`ifdef TMDS_ALIGN_STATS_EN
         ,.slip_cnt (o_slip_cnt[k*SLIP_W +: SLIP_W])
`endif
      );
   end

   // Link-level lock: every lane reports lock.
   always_ff @(posedge i_pixclk or negedge i_rst_n) begin
      if (!i_rst_n) o_all_locked <= 1'b0;
      else          o_all_locked <= &o_locked;
   end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Purpose: directed bench for tmds_word_aligner with a token-streak reference model.
// Latency: model tracks the registered outputs cycle by cycle.
// Backpressure: none. Slip counters are checked when TMDS_ALIGN_STATS_EN is defined.
module tb_tmds_word_aligner;

   localparam int NCH  = 3;
   localparam int S_TO = 16;
   localparam int L_CN = 8;
   localparam int L_TO = 32;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic [29:0] i_raw = '0;
   logic        i_realign = 1'b0;
   logic [29:0] o_word;
   logic [2:0]  o_locked;
   logic        o_all_locked;
   logic [11:0] o_offset;
`ifdef TMDS_ALIGN_STATS_EN
   logic [23:0] o_slip_cnt;
`endif

   tmds_word_aligner #(
      .NUM_CH(NCH), .SEARCH_TO(S_TO), .LOCK_CNT(L_CN), .LOSS_TO(L_TO)
   ) dut (
      .i_pixclk     (clk),
      .i_rst_n      (i_rst_n),
      .i_raw        (i_raw),
      .i_realign    (i_realign),
      .o_word       (o_word),
      .o_locked     (o_locked),
      .o_all_locked (o_all_locked),
      .o_offset     (o_offset)
`ifdef TMDS_ALIGN_STATS_EN
      ,.o_slip_cnt  (o_slip_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model: per lane, a streak of consecutive tokens and a run of quiet cycles.
   logic [9:0] m_prev[3];
   logic [9:0] m_word[3];
   bit         m_lk[3];
   bit         m_olk[3];
   bit         m_all;
   int         m_off[3];
   int         m_streak[3];
   int         m_quiet[3];
   int         m_slips[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_tok(input logic [9:0] c);
      logic [9:0] toks[4];
      toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
      foreach (toks[i]) if (c == toks[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [9:0] rotl(input logic [9:0] t, input int n);
      logic [19:0] d;
      d = {t, t} << n;
      return d[19:10];
   endfunction

   function automatic logic [9:0] pick(input logic [9:0] cur, input logic [9:0] prev, input int off);
      logic [19:0] w;
      w = {cur, prev} >> off;
      return w[9:0];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_prev[k] = '0; m_word[k] = '0; m_lk[k] = 0; m_olk[k] = 0;
         m_off[k] = 0; m_streak[k] = 0; m_quiet[k] = 0; m_slips[k] = 0;
      end
      m_all = 0;
   endtask

   task automatic slip_lane(input int k);
      m_off[k] = (m_off[k] + 1) % 10;
      if (m_slips[k] < 255) m_slips[k]++;
   endtask

   task automatic model_step(input logic [29:0] raw, input bit re);
      logic [9:0] c;
      bit t;
      m_all = m_olk[0] && m_olk[1] && m_olk[2];
      for (int k = 0; k < NCH; k++) begin
         c = pick(raw[k*10 +: 10], m_prev[k], m_off[k]);
         t = is_tok(c);
         m_word[k] = c;
         m_prev[k] = raw[k*10 +: 10];
         m_olk[k]  = m_lk[k];
         if (re) begin
            m_lk[k] = 0; m_streak[k] = 0; m_quiet[k] = 0;
         end else if (m_lk[k]) begin
            if (t) m_quiet[k] = 0;
            else begin
               m_quiet[k]++;
               if (m_quiet[k] == L_TO) begin
                  m_lk[k] = 0; m_quiet[k] = 0; m_streak[k] = 0;
                  slip_lane(k);
               end
            end
         end else if (t) begin
            m_quiet[k] = 0;
            m_streak[k]++;
            if (m_streak[k] == L_CN) begin
               m_lk[k] = 1; m_streak[k] = 0;
            end
         end else if (m_streak[k] > 0) begin
            // A broken streak restarts the hunt at the same offset with a fresh quiet count.
            m_streak[k] = 0; m_quiet[k] = 0;
         end else begin
            m_quiet[k]++;
            if (m_quiet[k] == S_TO) begin
               m_quiet[k] = 0;
               slip_lane(k);
            end
         end
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, return at the falling edge.
   task automatic cyc(input logic [29:0] raw, input bit re);
      i_raw = raw;
      i_realign = re;
      @(posedge clk);
      if (!i_rst_n) model_reset();
      else          model_step(raw, re);
      @(negedge clk);
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NCH; k++) begin
            chk($sformatf("word%0d", k),   32'(o_word[k*10 +: 10]), 32'(m_word[k]));
            chk($sformatf("locked%0d", k), 32'(o_locked[k]),        32'(m_olk[k]));
            chk($sformatf("offset%0d", k), 32'(o_offset[k*4 +: 4]), 32'(m_off[k]));
`ifdef TMDS_ALIGN_STATS_EN
            chk($sformatf("slips%0d", k),  32'(o_slip_cnt[k*8 +: 8]), 32'(m_slips[k]));
`endif
         end
         chk("all_locked", 32'(o_all_locked), 32'(m_all));
      end
   end

   localparam logic [9:0] T354 = 10'h354;
   localparam logic [9:0] T0AB = 10'h0AB;
   localparam logic [9:0] T154 = 10'h154;
   localparam logic [9:0] T2AB = 10'h2AB;

   initial begin
      logic [9:0]  l0, l1, l2, r1, l1_prev;
      logic [29:0] s;
      int rise[3];
      int rise_all;

      model_reset();
      #1 i_rst_n = 1'b0;
      chk_en = 1'b1;

      // Reset with random input: everything stays zero.
      for (int i = 0; i < 5; i++) begin
         cyc(30'($urandom), 1'b0);
         chk("rst_word",   32'(o_word),   32'h0);
         chk("rst_locked", 32'(o_locked), 32'h0);
         chk("rst_offset", 32'(o_offset), 32'h0);
      end
      i_rst_n = 1'b1;

      // Lane 0 carries a token rotated by 3 bits; it must slip 0->3 and lock.
      l0 = rotl(T354, 3);
      rise[0] = -1;
      for (int i = 1; i <= 70; i++) begin
         cyc({20'h0, l0}, 1'b0);
         if (i == 16) chk("t2_off_after16", 32'(o_offset[3:0]), 32'd1);
         if (o_locked[0] && rise[0] < 0) rise[0] = i;
      end
      chk("t2_lock_cycle", 32'(rise[0]), 32'd57);
      chk("t2_offset",     32'(o_offset[3:0]), 32'd3);
      chk("t2_word",       32'(o_word[9:0]), 32'(T354));

      // Asynchronous reset between edges clears outputs without a clock.
      #1 i_rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_word",   32'(o_word),   32'h0);
      chk("arst_locked", 32'(o_locked), 32'h0);
      chk("arst_offset", 32'(o_offset), 32'h0);
      for (int i = 0; i < 3; i++) cyc({20'h0, l0}, 1'b0);
      i_rst_n = 1'b1;

      // Three lanes at offsets 0, 5, 9 with different tokens.
      l0 = T0AB;
      l1 = rotl(T154, 5);
      l2 = rotl(T2AB, 9);
      s = {l2, l1, l0};
      for (int k = 0; k < NCH; k++) rise[k] = -1;
      rise_all = -1;
      for (int i = 1; i <= 170; i++) begin
         cyc(s, 1'b0);
         for (int k = 0; k < NCH; k++) if (o_locked[k] && rise[k] < 0) rise[k] = i;
         if (o_all_locked && rise_all < 0) rise_all = i;
      end
      chk("t3_rise0",   32'(rise[0]), 32'd10);
      chk("t3_rise1",   32'(rise[1]), 32'd89);
      chk("t3_rise2",   32'(rise[2]), 32'd153);
      chk("t3_riseall", 32'(rise_all), 32'd154);
      chk("t3_offsets", 32'(o_offset), 32'h950);

      // Realign while locked, then break lane 0's verify streak after four tokens.
      for (int k = 0; k < NCH; k++) rise[k] = -1;
      for (int p = 0; p <= 20; p++) begin
         cyc({l2, l1, (p == 4) ? 10'h000 : l0}, p == 0);
         if (p == 0) chk("t4_locked_p0", 32'(o_locked), 32'h7);
         if (p == 1) chk("t4_locked_p1", 32'(o_locked), 32'h0);
         if (p >= 1)
            for (int k = 0; k < NCH; k++) if (o_locked[k] && rise[k] < 0) rise[k] = p;
      end
      chk("t4_rise0",    32'(rise[0]), 32'd14);
      chk("t4_rise1",    32'(rise[1]), 32'd9);
      chk("t4_rise2",    32'(rise[2]), 32'd9);
      chk("t4_offsets",  32'(o_offset), 32'h950);

      // Loss of lock on lane 1: non-token data for LOSS_TO cycles.
      l1_prev = l1;
      for (int j = 1; j <= 34; j++) begin
         do r1 = 10'($urandom_range(0, 1023));
         while (is_tok(pick(r1, l1_prev, 5)));
         cyc({l2, r1, l0}, 1'b0);
         l1_prev = r1;
         if (j == 32) begin
            chk("t5_off1",     32'(o_offset[7:4]), 32'd6);
            chk("t5_lk1_held", 32'(o_locked[1]),   32'd1);
         end
         if (j == 33) chk("t5_lk1_drop", 32'(o_locked[1]), 32'd0);
      end
`ifdef TMDS_ALIGN_STATS_EN
      chk("t5_slipcnt1", 32'(o_slip_cnt[15:8]), 32'd6);
`endif
      for (int i = 0; i < 20; i++) cyc(s, 1'b0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
